// File: rtl/mips_multi_ctrl_fsm.sv
// Purpose     : main control FSM of the multicycle MIPS datapath; steps each
//               instruction through fetch, decode, execute, memory, writeback.
// Latency     : Moore outputs decoded from the state register; FETCH to next
//               FETCH takes lw 5, sw/R-type/addi 4, beq/j 3, illegal 2 cycles.
// Backpressure: none; advances one state per clock, no stall input.
// Ports       : clk, rst_n (async active-low); opcode_i (instr[31:26], used in
//               DECODE and MEMADR only); datapath selects iord_o, reg_dst_o,
//               mem_to_reg_o, alu_src_a_o, alu_src_b_o, alu_op_o, pc_source_o;
//               enables mem_write_o, ir_write_o, reg_write_o, pc_write_o,
//               branch_o; illegal_op_o one-cycle flag; state_o debug view.
// Option      : define MIPS_CTRL_BNE_EN to add the BNE state (opcode 000101)
//               and the branch_ne_o output.
module mips_multi_ctrl_fsm #(
  parameter int OP_W    = 6,
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [OP_W-1:0]    opcode_i,
  output logic               iord_o,
  output logic               mem_write_o,
  output logic               ir_write_o,
  output logic               reg_dst_o,
  output logic               mem_to_reg_o,
  output logic               reg_write_o,
  output logic               alu_src_a_o,
  output logic [1:0]         alu_src_b_o,
  output logic [1:0]         alu_op_o,
  output logic [1:0]         pc_source_o,
  output logic               pc_write_o,
  output logic               branch_o,
  output logic               illegal_op_o,
  output logic [STATE_W-1:0] state_o
`ifdef MIPS_CTRL_BNE_EN
  ,
  output logic               branch_ne_o
`endif
);

  typedef enum logic [STATE_W-1:0] {
    FETCH   = STATE_W'(0),
    DECODE  = STATE_W'(1),
    MEMADR  = STATE_W'(2),
    MEMRD   = STATE_W'(3),
    MEMWB   = STATE_W'(4),
    MEMWR   = STATE_W'(5),
    EXECUTE = STATE_W'(6),
    ALUWB   = STATE_W'(7),
    BRANCH  = STATE_W'(8),
    ADDIEX  = STATE_W'(9),
    ADDIWB  = STATE_W'(10),
    JUMP    = STATE_W'(11)
`ifdef MIPS_CTRL_BNE_EN
    ,
    BNE     = STATE_W'(12)
`endif
  } state_e;

  localparam logic [OP_W-1:0] OP_LW    = OP_W'(6'b100011);
  localparam logic [OP_W-1:0] OP_SW    = OP_W'(6'b101011);
  localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(6'b000000);
  localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(6'b000100);
  localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(6'b001000);
  localparam logic [OP_W-1:0] OP_J     = OP_W'(6'b000010);
`ifdef MIPS_CTRL_BNE_EN
  localparam logic [OP_W-1:0] OP_BNE   = OP_W'(6'b000101);
`endif

  state_e state_q;
  state_e state_d;
  logic   illegal_dec;

  // Next-state logic. Unreachable encodings fall into the default arm and
  // go back to FETCH; their output decode below leaves every enable at 0.
  always_comb begin
    state_d     = FETCH;
    illegal_dec = 1'b0;
    case (state_q)
      FETCH:   state_d = DECODE;
      DECODE: begin
        case (opcode_i)
          OP_LW,
          OP_SW:    state_d = MEMADR;
          OP_RTYPE: state_d = EXECUTE;
          OP_BEQ:   state_d = BRANCH;
          OP_ADDI:  state_d = ADDIEX;
          OP_J:     state_d = JUMP;
`ifdef MIPS_CTRL_BNE_EN
          OP_BNE:   state_d = BNE;
`endif
          default: begin
            state_d     = FETCH;
            illegal_dec = 1'b1;
          end
        endcase
      end
      MEMADR:  state_d = (opcode_i == OP_LW) ? MEMRD : MEMWR;
      MEMRD:   state_d = MEMWB;
      EXECUTE: state_d = ALUWB;
      ADDIEX:  state_d = ADDIWB;
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Output decode from the state register only (plus opcode in DECODE for
  // the illegal flag). Reset already parks state_q in FETCH, so the selects
  // show FETCH values; the enables are additionally masked by rst_n because
  // FETCH itself would otherwise assert ir_write and pc_write during reset.
  always_comb begin
    iord_o       = 1'b0;
    mem_write_o  = 1'b0;
    ir_write_o   = 1'b0;
    reg_dst_o    = 1'b0;
    mem_to_reg_o = 1'b0;
    reg_write_o  = 1'b0;
    alu_src_a_o  = 1'b0;
    alu_src_b_o  = 2'b00;
    alu_op_o     = 2'b00;
    pc_source_o  = 2'b00;
    pc_write_o   = 1'b0;
    branch_o     = 1'b0;
    illegal_op_o = 1'b0;
`ifdef MIPS_CTRL_BNE_EN
    branch_ne_o  = 1'b0;
`endif
    case (state_q)
      FETCH: begin
        ir_write_o  = 1'b1;
        alu_src_b_o = 2'b01;
        pc_write_o  = 1'b1;
      end
      DECODE: begin
        alu_src_b_o  = 2'b11;
        illegal_op_o = illegal_dec;
      end
      MEMADR: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = 2'b10;
      end
      MEMRD: iord_o = 1'b1;
      MEMWB: begin
        mem_to_reg_o = 1'b1;
        reg_write_o  = 1'b1;
      end
      MEMWR: begin
        iord_o      = 1'b1;
        mem_write_o = 1'b1;
      end
      EXECUTE: begin
        alu_src_a_o = 1'b1;
        alu_op_o    = 2'b10;
      end
      ALUWB: begin
        reg_dst_o   = 1'b1;
        reg_write_o = 1'b1;
      end
      BRANCH: begin
        alu_src_a_o = 1'b1;
        alu_op_o    = 2'b01;
        pc_source_o = 2'b01;
        branch_o    = 1'b1;
      end
`ifdef MIPS_CTRL_BNE_EN
      BNE: begin
        alu_src_a_o = 1'b1;
        alu_op_o    = 2'b01;
        pc_source_o = 2'b01;
        branch_o    = 1'b1;
        branch_ne_o = 1'b1;
      end
`endif
      ADDIEX: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = 2'b10;
      end
      ADDIWB: reg_write_o = 1'b1;
      JUMP: begin
        pc_source_o = 2'b10;
        pc_write_o  = 1'b1;
      end
      default: ;
    endcase
    if (!rst_n) begin
      mem_write_o  = 1'b0;
      ir_write_o   = 1'b0;
      reg_write_o  = 1'b0;
      pc_write_o   = 1'b0;
      branch_o     = 1'b0;
      illegal_op_o = 1'b0;
`ifdef MIPS_CTRL_BNE_EN
      branch_ne_o  = 1'b0;
`endif
    end
  end

  assign state_o = state_q;

endmodule

// File: tb/tb_mips_multi_ctrl_fsm.sv
// Purpose     : scoreboard bench for mips_multi_ctrl_fsm; expected per-cycle
//               outputs are queued by the driver and popped by a monitor.
// Latency     : one expected record per clock, compared at the falling edge.
// Backpressure: none.
`timescale 1ns/1ps
module tb_mips_multi_ctrl_fsm;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode_i;
  logic       iord_o, mem_write_o, ir_write_o, reg_dst_o, mem_to_reg_o;
  logic       reg_write_o, alu_src_a_o, pc_write_o, branch_o, illegal_op_o;
  logic [1:0] alu_src_b_o, alu_op_o, pc_source_o;
  logic [3:0] state_o;
  logic       bne_act;

`ifdef MIPS_CTRL_BNE_EN
  localparam bit BNE_EN = 1'b1;
  logic branch_ne_o;
  assign bne_act = branch_ne_o;
`else
  localparam bit BNE_EN = 1'b0;
  assign bne_act = 1'b0;
`endif

  mips_multi_ctrl_fsm #(.OP_W(6), .STATE_W(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .opcode_i     (opcode_i),
    .iord_o       (iord_o),
    .mem_write_o  (mem_write_o),
    .ir_write_o   (ir_write_o),
    .reg_dst_o    (reg_dst_o),
    .mem_to_reg_o (mem_to_reg_o),
    .reg_write_o  (reg_write_o),
    .alu_src_a_o  (alu_src_a_o),
    .alu_src_b_o  (alu_src_b_o),
    .alu_op_o     (alu_op_o),
    .pc_source_o  (pc_source_o),
    .pc_write_o   (pc_write_o),
    .branch_o     (branch_o),
    .illegal_op_o (illegal_op_o),
    .state_o      (state_o)
`ifdef MIPS_CTRL_BNE_EN
    ,
    .branch_ne_o  (branch_ne_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic       iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write;
    logic       alu_src_a;
    logic [1:0] src_b, alu_op, pc_src;
    logic       pc_write, branch, illegal, bne;
  } obs_t;

  obs_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  // Reference: per-state control word straight from the state table.
  function automatic obs_t expect_state(input int s, input bit ill, input bit in_rst);
    obs_t e;
    e    = '0;
    e.st = 4'(s);
    case (s)
      0:  begin e.ir_write = 1; e.src_b = 2'b01; e.pc_write = 1; end
      1:  begin e.src_b = 2'b11; e.illegal = ill; end
      2:  begin e.alu_src_a = 1; e.src_b = 2'b10; end
      3:  e.iord = 1;
      4:  begin e.mem_to_reg = 1; e.reg_write = 1; end
      5:  begin e.iord = 1; e.mem_write = 1; end
      6:  begin e.alu_src_a = 1; e.alu_op = 2'b10; end
      7:  begin e.reg_dst = 1; e.reg_write = 1; end
      8, 12: begin
        e.alu_src_a = 1; e.alu_op = 2'b01; e.pc_src = 2'b01; e.branch = 1;
        e.bne = (s == 12);
      end
      9:  begin e.alu_src_a = 1; e.src_b = 2'b10; end
      10: e.reg_write = 1;
      11: begin e.pc_src = 2'b10; e.pc_write = 1; end
      default: ;
    endcase
    if (in_rst) begin
      e.ir_write = 0;
      e.pc_write = 0;
    end
    return e;
  endfunction

  // Queue the whole state walk of one instruction; returns its cycle count.
  task automatic issue(input logic [5:0] op, output int ncyc);
    int seq[$];
    bit ill;
    ill = 1'b0;
    case (op)
      6'b100011: seq = '{0, 1, 2, 3, 4};
      6'b101011: seq = '{0, 1, 2, 5};
      6'b000000: seq = '{0, 1, 6, 7};
      6'b000100: seq = '{0, 1, 8};
      6'b001000: seq = '{0, 1, 9, 10};
      6'b000010: seq = '{0, 1, 11};
      6'b000101: begin
        if (BNE_EN) seq = '{0, 1, 12};
        else begin seq = '{0, 1}; ill = 1'b1; end
      end
      default: begin seq = '{0, 1}; ill = 1'b1; end
    endcase
    foreach (seq[i]) exp_q.push_back(expect_state(seq[i], ill && (seq[i] == 1), 1'b0));
    ncyc = seq.size();
  endtask

  task automatic run_instr(input logic [5:0] op);
    int n;
    opcode_i = op;
    issue(op, n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic obs_t sample();
    obs_t a;
    a = '{st: state_o, iord: iord_o, mem_write: mem_write_o, ir_write: ir_write_o,
          reg_dst: reg_dst_o, mem_to_reg: mem_to_reg_o, reg_write: reg_write_o,
          alu_src_a: alu_src_a_o, src_b: alu_src_b_o, alu_op: alu_op_o,
          pc_src: pc_source_o, pc_write: pc_write_o, branch: branch_o,
          illegal: illegal_op_o, bne: bne_act};
    return a;
  endfunction

  // Monitor: one expected record per falling edge.
  always @(negedge clk) begin
    obs_t a;
    obs_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      a = sample();
      vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL cycle_outputs t=%0t state actual=%0d required=%0d word actual=%h required=%h",
                 $time, a.st, e.st, a, e);
      end
      vectors++;
      if (($countones({a.reg_write, a.mem_write, a.ir_write}) > 1) || (a.pc_write && a.branch)) begin
        miscompares++;
        $display("FAIL enable_exclusive t=%0t actual=%h required=at most one write enable", $time, a);
      end
    end
  end

  logic [5:0] op_tab [8] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100,
                             6'b001000, 6'b000010, 6'b000101, 6'b111111};

  initial begin
    int k;
    rst_n    = 1'b0;
    opcode_i = 6'b0;
    repeat (3) exp_q.push_back(expect_state(0, 1'b0, 1'b1));
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b1;

    // Directed: lw, sw, R-type, beq, addi, j, illegal, bne.
    foreach (op_tab[i]) run_instr(op_tab[i]);

    // Asynchronous reset while the lw sits in MEMRD.
    opcode_i = 6'b100011;
    exp_q.push_back(expect_state(0, 1'b0, 1'b0));
    exp_q.push_back(expect_state(1, 1'b0, 1'b0));
    exp_q.push_back(expect_state(2, 1'b0, 1'b0));
    exp_q.push_back(expect_state(0, 1'b0, 1'b1));
    exp_q.push_back(expect_state(0, 1'b0, 1'b1));
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (state_o !== 4'd0 || reg_write_o !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset_drop state actual=%0d required=0 reg_write actual=%b required=0",
               state_o, reg_write_o);
    end
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    run_instr(6'b100011);

    // Randomised instruction stream, including arbitrary opcodes.
    for (int i = 0; i < 250; i++) begin
      k = $urandom_range(0, 8);
      if (k == 8) run_instr(6'($urandom_range(0, 63)));
      else        run_instr(op_tab[k]);
    end

    repeat (2) @(negedge clk);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL queue_drain actual=%0d required=0 records left", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mips_multi_ctrl_fsm.md
Name: mips_multi_ctrl_fsm

Overview:
- Main control state machine of the multicycle MIPS datapath.
- Sequences each instruction through fetch, decode, execute, memory and writeback.
- Drives every datapath mux select, including the 2-bit ALU source-B select of the 4:1 operand mux, plus all write enables.
- Sits upstream of the datapath muxes and register enables, and next to the ALU decoder, which consumes alu_op_o.

Parameters:
- OP_W, 6, opcode field width (instr[31:26]).
- STATE_W, 4, state register width; must hold 12 states.

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- opcode_i  input  OP_W  opcode from the instruction register; sampled only in DECODE and MEMADR.
- iord_o  output  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_write_o  output  1  memory write enable.
- ir_write_o  output  1  instruction register load enable.
- reg_dst_o  output  1  write register select: 0 = rt, 1 = rd.
- mem_to_reg_o  output  1  writeback data select: 0 = ALUOut, 1 = MDR.
- reg_write_o  output  1  register file write enable.
- alu_src_a_o  output  1  ALU A select: 0 = PC, 1 = reg A.
- alu_src_b_o  output  2  ALU B select: 00 = reg B, 01 = constant 4, 10 = sign-extended imm, 11 = imm<<2.
- alu_op_o  output  2  00 = add, 01 = sub, 10 = use funct.
- pc_source_o  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- pc_write_o  output  1  unconditional PC write.
- branch_o  output  1  conditional PC write on zero.
- illegal_op_o  output  1  one-cycle flag: unknown opcode decoded.
- state_o  output  STATE_W  current state encoding, for debug.

Behaviour:
- Output style: Moore. All outputs decode from the state register only, except illegal_op_o, which also decodes opcode_i in DECODE.
- Reset: while rst_n=0, state=FETCH. Enables (pc_write_o, ir_write_o, mem_write_o, reg_write_o, branch_o) and illegal_op_o are forced 0. Selects take their FETCH values.
- Reset mid-instruction: abandons the instruction immediately. No write enable is asserted on the first edge after release until FETCH executes.
- Unlisted outputs are 0 in every state.
- FETCH: iord=0, ir_write=1, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00, pc_write=1. Next state: DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target computed). Next state by opcode:
  - 100011 or 101011 -> MEMADR
  - 000000 -> EXECUTE
  - 000100 -> BRANCH
  - 001000 -> ADDIEX
  - 000010 -> JUMP
  - any other -> FETCH, with illegal_op_o=1 for this cycle.
- MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. Next: MEMRD if opcode=100011, else MEMWR.
- MEMRD: iord=1. Next: MEMWB.
- MEMWB: reg_dst=0, mem_to_reg=1, reg_write=1. Next: FETCH.
- MEMWR: iord=1, mem_write=1. Next: FETCH.
- EXECUTE: alu_src_a=1, alu_src_b=00, alu_op=10. Next: ALUWB.
- ALUWB: reg_dst=1, mem_to_reg=0, reg_write=1. Next: FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_source=01, branch=1. Next: FETCH.
- ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00. Next: ADDIWB.
- ADDIWB: reg_dst=0, mem_to_reg=0, reg_write=1. Next: FETCH.
- JUMP: pc_source=10, pc_write=1. Next: FETCH.
- Cycle counts, FETCH to next FETCH: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.
- Write-enable exclusivity: reg_write, mem_write and ir_write are never high together. pc_write and branch are never high together.
- Unreachable state encodings return to FETCH on the next edge with all enables 0.
- state_o encoding is fixed: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11, BNE=12.

Optional Feature:
- Macro: MIPS_CTRL_BNE_EN.
- Defined:
  - Opcode 000101 in DECODE goes to state BNE, which drives the same outputs as BRANCH.
  - Adds output branch_ne_o (1 bit); the datapath writes the PC when branch_ne_o=1 and zero=0.
  - branch_ne_o is 1 only in BNE and 0 in reset.
- Undefined:
  - Opcode 000101 is illegal: illegal_op_o pulses and the FSM returns to FETCH.
  - The branch_ne_o port and the BNE state do not exist.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles, then release. During reset, state_o=0 and all enables are 0. On the first cycle after release, ir_write_o=1, pc_write_o=1, alu_src_b_o=01.
- lw: opcode 100011. state_o sequence is 0,1,2,3,4,0. alu_src_b_o=10 in MEMADR. reg_write_o=1 with mem_to_reg_o=1 only in state 4.
- sw, then R-type: 101011 gives 0,1,2,5,0 with mem_write_o=1 only in 5. 000000 gives 0,1,6,7,0 with alu_src_b_o=00, alu_op_o=10 in 6, and reg_dst_o=1 in 7.
- beq, j, illegal: 000100 gives 0,1,8,0 with branch_o=1, alu_op_o=01. 000010 gives 0,1,11,0 with pc_source_o=10. 111111 gives 0,1,0 with illegal_op_o=1 only in cycle 1.
- Reset mid-lw: assert rst_n=0 asynchronously during state 3. state_o drops to 0 immediately, no reg_write_o pulse occurs, and normal fetch resumes after release.
- BNE: with MIPS_CTRL_BNE_EN, 000101 gives 0,1,12,0 with branch_ne_o=1 only in 12. Without it, illegal_op_o=1 in DECODE.
